// File: rtl/mc_pkg.sv
// Shared types for the DDR command scheduler: command codes,
// scheduler states and the request layout popped from the FIFO.
package mc_pkg;

  localparam int MC_BA_W  = 2;
  localparam int MC_ROW_W = 14;
  localparam int MC_COL_W = 10;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_RW,
    S_PREA,
    S_REF,
    S_WAIT,
    S_PRE_CL
  } state_e;

  typedef struct packed {
    logic                we;
    logic [MC_BA_W-1:0]  ba;
    logic [MC_ROW_W-1:0] row;
    logic [MC_COL_W-1:0] col;
  } req_t;

endpackage

// File: rtl/mc_bank_tracker.sv
// Per-bank open flag and open-row store with hit lookup,
// used by the scheduler only in the open-page build.
module mc_bank_tracker #(
  parameter int BA_W  = 2,
  parameter int ROW_W = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [BA_W-1:0]  lk_ba_i,
  input  logic [ROW_W-1:0] lk_row_i,
  input  logic [BA_W-1:0]  upd_ba_i,
  input  logic [ROW_W-1:0] upd_row_i,
  input  logic             open_i,
  input  logic             close_i,
  input  logic             close_all_i,
  output logic             hit_o,
  output logic             open_o,
  output logic             any_open_o
);

  localparam int BANKS = 2 ** BA_W;

  logic [BANKS-1:0] open_q, open_d;
  logic [ROW_W-1:0] row_q [BANKS];
  logic [ROW_W-1:0] row_d [BANKS];

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (close_all_i) begin
      open_d = '0;
    end else if (close_i) begin
      open_d[upd_ba_i] = 1'b0;
    end
    if (open_i) begin
      open_d[upd_ba_i] = 1'b1;
      row_d[upd_ba_i]  = upd_row_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      open_q <= '0;
      for (int i = 0; i < BANKS; i++) row_q[i] <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

  assign open_o     = open_q[lk_ba_i];
  assign hit_o      = open_o && (row_q[lk_ba_i] == lk_row_i);
  assign any_open_o = |open_q;

endmodule

// File: rtl/mc_cmd_sched.sv
// Expands FIFO requests into timed DDR commands with periodic refresh.
// Define MC_SCHED_OPEN_PAGE_EN for open-page; closed-page otherwise.
module mc_cmd_sched
  import mc_pkg::*;
#(
  parameter int BA_W   = 2,
  parameter int ROW_W  = 14,
  parameter int COL_W  = 10,
  parameter int T_RP   = 3,
  parameter int T_RCD  = 3,
  parameter int T_CCD  = 2,
  parameter int T_WR   = 4,
  parameter int T_RFC  = 8,
  parameter int T_REFI = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      req_pop_o,
  input  logic                      req_vld_i,
  input  logic [BA_W+ROW_W+COL_W:0] req_data_i,
  output logic                      cmd_vld_o,
  output logic [2:0]                cmd_o,
  output logic [BA_W-1:0]           cmd_ba_o,
  output logic [((ROW_W > COL_W) ? ROW_W : COL_W)-1:0] cmd_addr_o,
  output logic                      busy_o
);

  localparam int REQ_W = 1 + BA_W + ROW_W + COL_W;
  localparam int AW    = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int CW    = 8;
  localparam int RFW   = $clog2(T_REFI + 1);

  state_e           state_q, state_d, nxt_q, nxt_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [RFW-1:0]   refi_cnt_q, refi_cnt_d;
  logic             ref_pend_q, ref_pend_d;
  logic [REQ_W-1:0] req_q, req_d;
  cmd_e             cmd_q, cmd_d;
  logic             cmd_vld_q, cmd_vld_d;
  logic [BA_W-1:0]  cmd_ba_q, cmd_ba_d;
  logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
  logic             busy_q, busy_d;

  int     tload;
  state_e tnext;
  logic   tgo;

  logic             d_we;
  logic [BA_W-1:0]  d_ba;
  logic [ROW_W-1:0] d_row;
  logic [COL_W-1:0] d_col;

  assign {d_we, d_ba, d_row, d_col} = req_d;

`ifdef MC_SCHED_OPEN_PAGE_EN
  logic bank_hit, bank_open, any_open;

  mc_bank_tracker #(
    .BA_W  (BA_W),
    .ROW_W (ROW_W)
  ) u_bank (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lk_ba_i     (req_data_i[COL_W+ROW_W +: BA_W]),
    .lk_row_i    (req_data_i[COL_W +: ROW_W]),
    .upd_ba_i    (req_q[COL_W+ROW_W +: BA_W]),
    .upd_row_i   (req_q[COL_W +: ROW_W]),
    .open_i      (state_q == S_ACT),
    .close_i     (state_q == S_PRE),
    .close_all_i (state_q == S_PREA),
    .hit_o       (bank_hit),
    .open_o      (bank_open),
    .any_open_o  (any_open)
  );
`endif

  assign req_pop_o = (state_q == S_IDLE) && !ref_pend_q;

  always_comb begin
    state_d    = state_q;
    nxt_d      = nxt_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    ref_pend_d = ref_pend_q;
    refi_cnt_d = refi_cnt_q + RFW'(1);
    tgo        = 1'b0;
    tload      = 1;
    tnext      = S_IDLE;
    unique case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
`ifdef MC_SCHED_OPEN_PAGE_EN
          state_d = any_open ? S_PREA : S_REF;
`else
          state_d = S_REF;
`endif
        end else if (req_vld_i) begin
          req_d = req_data_i;
`ifdef MC_SCHED_OPEN_PAGE_EN
          unique case (1'b1)
            bank_hit:               state_d = S_RW;
            bank_open && !bank_hit: state_d = S_PRE;
            default:                state_d = S_ACT;
          endcase
`else
          state_d = S_ACT;
`endif
        end
      end
      S_PRE:    begin tgo = 1'b1; tload = T_RP;  tnext = S_ACT;  end
      S_ACT:    begin tgo = 1'b1; tload = T_RCD; tnext = S_RW;   end
`ifdef MC_SCHED_OPEN_PAGE_EN
      S_RW:     begin tgo = 1'b1; tload = T_CCD; tnext = S_IDLE; end
`else
      S_RW:     begin tgo = 1'b1; tload = T_WR;  tnext = S_PRE_CL; end
`endif
      S_PRE_CL: begin tgo = 1'b1; tload = T_RP;  tnext = S_IDLE; end
      S_PREA:   begin tgo = 1'b1; tload = T_RP;  tnext = S_REF;  end
      S_REF: begin
        ref_pend_d = 1'b0;
        tgo        = 1'b1;
        tload      = T_RFC;
        tnext      = S_IDLE;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - CW'(1);
        if (wait_cnt_q == CW'(1)) state_d = nxt_q;
      end
      default: state_d = S_IDLE;
    endcase
    // a timing of one cycle goes straight on without visiting WAIT
    if (tgo) begin
      if (tload <= 1) begin
        state_d = tnext;
      end else begin
        wait_cnt_d = CW'(tload - 1);
        nxt_d      = tnext;
        state_d    = S_WAIT;
      end
    end
    if (refi_cnt_q == RFW'(T_REFI - 1)) begin
      refi_cnt_d = '0;
      ref_pend_d = 1'b1;
    end
  end

  // outputs are registered from the state being entered
  always_comb begin
    cmd_d      = CMD_NOP;
    cmd_ba_d   = '0;
    cmd_addr_d = '0;
    unique case (state_d)
      S_PRE, S_PRE_CL: begin
        cmd_d    = CMD_PRE;
        cmd_ba_d = d_ba;
      end
      S_ACT: begin
        cmd_d      = CMD_ACT;
        cmd_ba_d   = d_ba;
        cmd_addr_d = AW'(d_row);
      end
      S_RW: begin
        cmd_d      = d_we ? CMD_WR : CMD_RD;
        cmd_ba_d   = d_ba;
        cmd_addr_d = AW'(d_col);
      end
      S_PREA:  cmd_d = CMD_PREA;
      S_REF:   cmd_d = CMD_REF;
      default: cmd_d = CMD_NOP;
    endcase
    cmd_vld_d = (cmd_d != CMD_NOP);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      nxt_q      <= S_IDLE;
      wait_cnt_q <= '0;
      refi_cnt_q <= '0;
      ref_pend_q <= 1'b0;
      req_q      <= '0;
      cmd_q      <= CMD_NOP;
      cmd_vld_q  <= 1'b0;
      cmd_ba_q   <= '0;
      cmd_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      wait_cnt_q <= wait_cnt_d;
      refi_cnt_q <= refi_cnt_d;
      ref_pend_q <= ref_pend_d;
      req_q      <= req_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_ba_q   <= cmd_ba_d;
      cmd_addr_q <= cmd_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_o      = cmd_q;
  assign cmd_vld_o  = cmd_vld_q;
  assign cmd_ba_o   = cmd_ba_q;
  assign cmd_addr_o = cmd_addr_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_mc_cmd_sched.sv
// Bench for mc_cmd_sched: vector table, directed timing sequences
// and randomized traffic against a schedule-level reference model.
module tb_mc_cmd_sched;
  import mc_pkg::*;

  localparam int T_RP   = 3;
  localparam int T_RCD  = 3;
  localparam int T_CCD  = 2;
  localparam int T_WR   = 4;
  localparam int T_RFC  = 8;
  localparam int T_REFI = 64;
  localparam int BANKS  = 4;
  localparam int NCYC   = 4096;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_vld_i = 1'b0;
  req_t        req_data_i = '0;
  logic        req_pop_o;
  logic        cmd_vld_o;
  logic [2:0]  cmd_o;
  logic [1:0]  cmd_ba_o;
  logic [13:0] cmd_addr_o;
  logic        busy_o;

  always #5 clk = ~clk;

  mc_cmd_sched dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_pop_o  (req_pop_o),
    .req_vld_i  (req_vld_i),
    .req_data_i (req_data_i),
    .cmd_vld_o  (cmd_vld_o),
    .cmd_o      (cmd_o),
    .cmd_ba_o   (cmd_ba_o),
    .cmd_addr_o (cmd_addr_o),
    .busy_o     (busy_o)
  );

  int n_chk = 0;
  int n_pass = 0;
  int t;
  int idle_at;
  int ref_at;
  bit pend_m;
  bit open_m [BANKS];
  int row_m [BANKS];
  int e_cmd [NCYC];
  int e_ba [NCYC];
  int e_addr [NCYC];
  bit e_busy [NCYC];
  int l_cmd [NCYC];
  int l_ba [NCYC];
  int l_addr [NCYC];
  bit l_busy [NCYC];
  bit l_pop [NCYC];
  bit l_acc [NCYC];
  req_t fifo [$];

  typedef struct {
    bit vld;
    bit pop;
    int cmd;
    int ba;
    int addr;
    bit busy;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
  endtask

  function automatic req_t mk(bit we, int ba, int row, int col);
    req_t r;
    r.we  = we;
    r.ba  = 2'(ba);
    r.row = 14'(row);
    r.col = 10'(col);
    return r;
  endfunction

  function automatic void sched(int c, int k, int ba, int addr);
    if (c < NCYC) begin
      e_cmd[c]  = k;
      e_ba[c]   = ba;
      e_addr[c] = addr;
    end
  endfunction

  function automatic void mark_busy(int from, int to);
    for (int c = from; c < to && c < NCYC; c++) e_busy[c] = 1'b1;
  endfunction

  // schedule every command of one request from the timing rules
  function automatic void model_accept(req_t r);
    int c = t + 1;
    int ba = int'(r.ba);
    int row = int'(r.row);
`ifdef MC_SCHED_OPEN_PAGE_EN
    if (!(open_m[ba] && row_m[ba] == row)) begin
      if (open_m[ba]) begin
        sched(c, CMD_PRE, ba, 0);
        c += T_RP;
      end
      sched(c, CMD_ACT, ba, row);
      open_m[ba] = 1'b1;
      row_m[ba]  = row;
      c += T_RCD;
    end
    sched(c, r.we ? CMD_WR : CMD_RD, ba, int'(r.col));
    c += T_CCD;
`else
    sched(c, CMD_ACT, ba, row);
    c += T_RCD;
    sched(c, r.we ? CMD_WR : CMD_RD, ba, int'(r.col));
    c += T_WR;
    sched(c, CMD_PRE, ba, 0);
    c += T_RP;
`endif
    mark_busy(t + 1, c);
    idle_at = c;
  endfunction

  function automatic void model_refresh();
    int c = t + 1;
    bit any = 1'b0;
    for (int b = 0; b < BANKS; b++) any |= open_m[b];
    if (any) begin
      sched(c, CMD_PREA, 0, 0);
      for (int b = 0; b < BANKS; b++) open_m[b] = 1'b0;
      c += T_RP;
    end
    sched(c, CMD_REF, 0, 0);
    ref_at = c;
    c += T_RFC;
    mark_busy(t + 1, c);
    idle_at = c;
  endfunction

  function automatic void model_clear();
    t = 0;
    idle_at = 0;
    ref_at = -1;
    pend_m = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      open_m[b] = 1'b0;
      row_m[b]  = 0;
    end
    for (int c = 0; c < NCYC; c++) begin
      e_cmd[c] = 0; e_ba[c] = 0; e_addr[c] = 0; e_busy[c] = 1'b0;
      l_cmd[c] = 0; l_ba[c] = 0; l_addr[c] = 0; l_busy[c] = 1'b0;
      l_pop[c] = 1'b0; l_acc[c] = 1'b0;
    end
    fifo.delete();
  endfunction

  task automatic do_reset();
    req_vld_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_clear();
  endtask

  task automatic step();
    bit pop_e;
    req_t r;
    pop_e = (t >= idle_at) && !pend_m;
    chk("pop", int'(req_pop_o), int'(pop_e));
    chk("cmd", int'(cmd_o), e_cmd[t]);
    chk("vld", int'(cmd_vld_o), int'(e_cmd[t] != 0));
    chk("ba", int'(cmd_ba_o), e_ba[t]);
    chk("addr", int'(cmd_addr_o), e_addr[t]);
    chk("busy", int'(busy_o), int'(e_busy[t]));
    l_cmd[t]  = int'(cmd_o);
    l_ba[t]   = int'(cmd_ba_o);
    l_addr[t] = int'(cmd_addr_o);
    l_busy[t] = busy_o;
    l_pop[t]  = req_pop_o;
    req_vld_i = 1'b0;
    if (t >= idle_at && pend_m) begin
      model_refresh();
    end else if (pop_e && fifo.size() > 0) begin
      r = fifo.pop_front();
      req_data_i = r;
      req_vld_i = 1'b1;
      l_acc[t] = 1'b1;
      model_accept(r);
    end
    if (t == ref_at) pend_m = 1'b0;
    if (t % T_REFI == T_REFI - 1) pend_m = 1'b1;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  function automatic int find(int k, int from);
    if (from < 0) return -1;
    for (int c = from; c < NCYC; c++) if (l_cmd[c] == k) return c;
    return -1;
  endfunction

  function automatic int next_acc(int from);
    for (int c = from; c < NCYC; c++) if (l_acc[c]) return c;
    return -1;
  endfunction

  initial begin
    int a, r1, r2, p, w, rf, pa, np, nlow;
    req_t wr_req;

    // single WR {ba=2,row=0x123,col=0x40} popped at cycle 0
    wr_req = mk(1'b1, 2, 'h123, 'h40);
    for (int i = 0; i < 12; i++) tbl[i] = '{0, 0, 0, 0, 0, 1};
    tbl[0] = '{1, 1, CMD_NOP, 0, 0, 0};
    tbl[1] = '{0, 0, CMD_ACT, 2, 'h123, 1};
    tbl[4] = '{0, 0, CMD_WR, 2, 'h40, 1};
`ifdef MC_SCHED_OPEN_PAGE_EN
    for (int i = 6; i < 12; i++) tbl[i] = '{0, 1, 0, 0, 0, 0};
`else
    tbl[8]  = '{0, 0, CMD_PRE, 2, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 0, 0};
`endif

    do_reset();
    for (int i = 0; i < 12; i++) begin
      t = i;
      req_vld_i  = tbl[i].vld;
      req_data_i = wr_req;
      chk("tbl_pop", int'(req_pop_o), int'(tbl[i].pop));
      chk("tbl_cmd", int'(cmd_o), tbl[i].cmd);
      chk("tbl_vld", int'(cmd_vld_o), int'(tbl[i].cmd != 0));
      chk("tbl_ba", int'(cmd_ba_o), tbl[i].ba);
      chk("tbl_addr", int'(cmd_addr_o), tbl[i].addr);
      chk("tbl_busy", int'(busy_o), int'(tbl[i].busy));
      @(posedge clk);
      #1;
    end
    req_vld_i = 1'b0;

`ifdef MC_SCHED_OPEN_PAGE_EN
    // row hit back-to-back
    do_reset();
    fifo.push_back(mk(1'b0, 1, 5, 7));
    fifo.push_back(mk(1'b0, 1, 5, 8));
    run(20);
    a  = find(CMD_ACT, 0);
    r1 = find(CMD_RD, 0);
    r2 = find(CMD_RD, r1 + 1);
    chk("hit_gap", r2 - r1, T_CCD + 1);
    chk("hit_act2", find(CMD_ACT, a + 1), -1);
    chk("hit_col", l_addr[r2], 8);

    // row miss
    do_reset();
    fifo.push_back(mk(1'b0, 1, 5, 7));
    fifo.push_back(mk(1'b0, 1, 6, 9));
    run(25);
    r1 = find(CMD_RD, 0);
    p  = find(CMD_PRE, r1);
    a  = find(CMD_ACT, p);
    r2 = find(CMD_RD, a);
    chk("miss_pre", p - r1, T_CCD + 1);
    chk("miss_act", a - p, T_RP);
    chk("miss_row", l_addr[a], 6);
    chk("miss_rd", r2 - a, T_RCD);
`else
    // closed-page single read
    do_reset();
    fifo.push_back(mk(1'b0, 1, 5, 7));
    run(20);
    a = find(CMD_ACT, 0);
    r1 = find(CMD_RD, 0);
    p = find(CMD_PRE, r1);
    chk("cp_rcd", r1 - a, T_RCD);
    chk("cp_wr", p - r1, T_WR);
    chk("cp_pre_ba", l_ba[p], 1);
    chk("cp_busy_hi", int'(l_busy[p + 2]), 1);
    chk("cp_busy_lo", int'(l_busy[p + 3]), 0);
`endif

    // refresh expiry while a request is in flight
    do_reset();
    run(59);
    fifo.push_back(mk(1'b1, 2, 'h11, 'h22));
    fifo.push_back(mk(1'b0, 3, 4, 5));
    run(45);
    w = find(CMD_WR, 0);
    chk("ref_wr", w, 63);
`ifdef MC_SCHED_OPEN_PAGE_EN
    pa = find(CMD_PREA, w);
    chk("ref_prea", pa, 66);
    rf = find(CMD_REF, pa);
    chk("ref_trp", rf - pa, T_RP);
`else
    pa = find(CMD_PRE, w);
    chk("ref_prcl", pa - w, T_WR);
    rf = find(CMD_REF, pa);
    chk("ref_after", rf - pa, T_RP + 1);
    chk("ref_noprea", find(CMD_PREA, 0), -1);
`endif
    np = next_acc(w + 1);
    chk("ref_rfc", np - rf, T_RFC);
    nlow = 0;
    for (int c = 64; c <= rf && c >= 0; c++) nlow += int'(l_pop[c]);
    chk("ref_poplow", nlow, 0);

    // reset in the ACT-to-RW window
    do_reset();
    fifo.push_back(mk(1'b0, 1, 5, 7));
    run(1);
    chk("mid_act", int'(cmd_o), CMD_ACT);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_cmd", int'(cmd_o), CMD_NOP);
    chk("mid_vld", int'(cmd_vld_o), 0);
    chk("mid_busy", int'(busy_o), 0);
    chk("mid_addr", int'(cmd_addr_o), 0);
    do_reset();
    fifo.push_back(mk(1'b0, 1, 5, 7));
    run(10);
    chk("post_act", find(CMD_ACT, 0), 1);
    chk("post_row", l_addr[1], 5);
    chk("post_rd", find(CMD_RD, 0), 1 + T_RCD);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (fifo.size() < 4 && $urandom_range(0, 2) != 0)
        fifo.push_back(mk(1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 1023))));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
